instr_fetch: RTL and testbench



---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_timer.sv | 44 ++++
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    FAULT = 3'd4
  } fetch_state_e;

  // addi x0,x0,0 -- harmless word shown to the decoder before the first fetch
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Instruction addresses must sit on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timer.sv
// Wait-cycle counter for outstanding instruction memory requests.
// expired flags the cycle in which the count reaches TIMEOUT_CYCLES, so the
// FSM leaves WAIT at the same edge the limit is hit (exactly TIMEOUT_CYCLES
// WAIT cycles without a response).
module fetch_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear has priority over counting.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Limit reached by this cycle's increment.
  always_comb begin
    expired = enable && !clear && (count_d == LIMIT);
  end

endmodule

// File: rtl/instr_fetch.sv
// Multi-cycle instruction fetch unit: PC, memory handshake, instruction register.
// Every output is a register or a decode of the state register.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic        fetch_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         timer_clear;
  logic         timer_enable;
  logic         timer_expired;

  // Counter restarts in REQ so it reads zero on the first WAIT cycle.
  assign timer_clear  = (state_q == REQ);
  assign timer_enable = (state_q == WAIT) && !imem_rvalid;

  fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expired(timer_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; inputs only matter in the state that consumes them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = REQ;
      REQ:   state_d = WAIT;
      WAIT: begin
        if (imem_rvalid) begin
          state_d = HOLD;
        end else if (timer_expired) begin
          state_d = FAULT;
        end
      end
      HOLD: begin
        if (exec_done) begin
          if (branch_taken && !is_word_aligned(branch_target)) begin
            state_d = FAULT;
          end else begin
            state_d = REQ;
          end
        end
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  // Next PC and instruction capture; a misaligned target leaves pc untouched.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    if ((state_q == WAIT) && imem_rvalid) begin
      instr_d = imem_rdata;
    end
    if ((state_q == HOLD) && exec_done) begin
      if (!branch_taken) begin
        pc_d = pc_q + PC_STEP;
      end else if (is_word_aligned(branch_target)) begin
        pc_d = branch_target;
      end
    end
  end

  // PC and instruction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    imem_req    = (state_q == REQ);
    imem_addr   = pc_q;
    pc          = pc_q;
    instr       = instr_q;
    instr_valid = (state_q == HOLD);
    fetch_fault = (state_q == FAULT);
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard queues for fetch addresses
// and returned instruction words.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .fetch_fault  (fetch_fault)
  );

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] cur_pc   = 32'h0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[19:0], 12'h093};
  endfunction

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_pc"},    pc, RST_PC);
    check_eq({tag, "_instr"}, instr, NOP);
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check_eq({tag, "_req"},   32'(imem_req), 32'd0);
    check_eq({tag, "_fault"}, 32'(fetch_fault), 32'd0);
  endtask

  // Wait (bounded) for a request strobe, compare it with the scoreboard head.
  task automatic wait_req(input string tag, output logic [31:0] addr);
    int n = 0;
    logic [31:0] exp;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    if (exp_addr_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
      exp = 32'h0;
    end else begin
      exp = exp_addr_q.pop_front();
    end
    check_eq({tag, "_req"}, 32'(imem_req), 32'd1);
    check_eq({tag, "_addr"}, imem_addr, exp);
    cur_pc = exp;
    addr = exp;
  endtask

  // Memory model: answer lat cycles after the request (lat>=1).
  task automatic respond(input string tag, input logic [31:0] addr, input int lat, input bit stray_exec);
    logic [31:0] d;
    d = mem_word(addr);
    tick();
    for (int i = 1; i < lat; i++) begin
      if (stray_exec && i == 1) begin
        exec_done = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0200;
      end
      tick();
      exec_done = 1'b0;
      branch_taken = 1'b0;
    end
    imem_rvalid = 1'b1;
    imem_rdata = d;
    exp_instr_q.push_back(d);
    tick();
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check_eq({tag, "_instr"}, instr, exp_instr_q.pop_front());
    $display("fetch %s addr=%h instr=%h cycle=%0d", tag, addr, instr, cyc);
  endtask

  // Signal completion in HOLD and predict what happens next.
  task automatic finish_instr(input string tag, input bit br, input logic [31:0] tgt);
    exec_done = 1'b1;
    branch_taken = br;
    branch_target = tgt;
    tick();
    exec_done = 1'b0;
    branch_taken = 1'b0;
    check_eq({tag, "_valid_drop"}, 32'(instr_valid), 32'd0);
    if (br && tgt[1:0] != 2'b00) begin
      check_eq({tag, "_fault"}, 32'(fetch_fault), 32'd1);
      check_eq({tag, "_pc_kept"}, pc, cur_pc);
    end else begin
      exp_addr_q.push_back(br ? tgt : cur_pc + 32'd4);
    end
  endtask

  initial begin
    logic [31:0] a;
    int n;
    rst = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    exec_done = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    tick();
    tick();
    check_reset_values("reset");

    // First fetch: request in cycle 1, instruction valid in cycle 3.
    rst = 1'b0;
    cyc = 0;
    exp_addr_q.push_back(RST_PC);
    tick();
    wait_req("first", a);
    check_eq("first_req_cycle", 32'(cyc), 32'd1);
    respond("first", a, 1, 1'b0);
    check_eq("first_valid_cycle", 32'(cyc), 32'd3);

    // Stray rvalid in HOLD must not touch instr.
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check_eq("hold_rvalid_instr", instr, 32'h0050_0093);
    check_eq("hold_rvalid_valid", 32'(instr_valid), 32'd1);

    // Branch to 0x10, then sequential to 0x14.
    finish_instr("br10", 1'b1, 32'h0000_0010);
    wait_req("br10", a);
    respond("br10", a, 1, 1'b0);
    finish_instr("seq14", 1'b0, 32'h0);
    wait_req("seq14", a);
    respond("seq14", a, 3, 1'b1);
    check_eq("wait_exec_pc", pc, 32'h0000_0014);

    // Branch to 0x100, then to the top word and wrap to zero.
    finish_instr("br100", 1'b1, 32'h0000_0100);
    wait_req("br100", a);
    respond("br100", a, 1, 1'b0);
    finish_instr("brtop", 1'b1, 32'hFFFF_FFFC);
    wait_req("brtop", a);
    respond("brtop", a, 2, 1'b0);
    finish_instr("wrap", 1'b0, 32'h0);
    wait_req("wrap", a);
    respond("wrap", a, 1, 1'b0);

    // Misaligned branch target: sticky fault, no more requests.
    finish_instr("mis", 1'b1, 32'h0000_0102);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      imem_rvalid = 1'b1;
      tick();
      if (imem_req) n++;
    end
    imem_rvalid = 1'b0;
    check_eq("fault_no_req", 32'(n), 32'd0);
    check_eq("fault_sticky", 32'(fetch_fault), 32'd1);
    check_eq("fault_valid", 32'(instr_valid), 32'd0);
    $display("fault misaligned target pc=%h cycle=%0d", pc, cyc);

    // Reset out of FAULT, then memory never answers.
    rst = 1'b1;
    tick();
    check_reset_values("rst_fault");
    rst = 1'b0;
    exp_addr_q.push_back(RST_PC);
    wait_req("tmo", a);
    n = 0;
    while (!fetch_fault && n < 20) begin
      tick();
      n++;
    end
    // four WAIT cycles, then the FAULT cycle
    check_eq("timeout_ticks", 32'(n), 32'd5);
    check_eq("timeout_instr", instr, NOP);
    check_eq("timeout_req", 32'(imem_req), 32'd0);
    $display("timeout fault after %0d cycles from request", n);

    // Reset during WAIT, stale response arriving in IDLE.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_addr_q.push_back(RST_PC);
    wait_req("pre_rst", a);
    tick();
    rst = 1'b1;
    tick();
    check_reset_values("rst_wait");
    rst = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    check_eq("stale_instr", instr, NOP);
    exp_addr_q.push_back(RST_PC);
    wait_req("restart", a);
    respond("restart", a, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
